// File: rtl/load_burst.sv
// Multi-word load unit: on an armed LOAD opcode it requests a 1..DEPTH word burst,
// captures the beats into a local buffer and pulses is_loaded (or load_err on timeout/short burst).
module load_burst #(
    parameter int          DW      = 16,
    parameter int          AW      = 16,
    parameter int          DEPTH   = 4,
    parameter int          LW      = 3,
    parameter logic [7:0]  OPCODE  = 8'h02,
    parameter int          TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   instruction,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] burst_len,
    input  logic [DW-1:0] MDR,
    input  logic [DW-1:0] in_mem_data,
    input  logic          read_mem_valid,
    input  logic          read_mem_finish,
    output logic          read_mem_req,
    output logic [AW-1:0] read_mem_addr,
    output logic [DW-1:0] load_out,
    output logic          is_loaded,
    output logic          load_err,
    output logic          busy,
    input  logic [LW-1:0] rd_idx,
    output logic [DW-1:0] rd_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

    localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LW-1:0] LEN_MAX    = LW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          armed_q, armed_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    logic          trigger;
    logic          beat;
    logic          timed_out;
    logic [LW-1:0] cnt_post;
    logic [LW-1:0] len_clamped;

    // Handshake: a beat is consumed on any cycle in REQ where read_mem_valid=1 and
    // the burst is not yet full; read_mem_finish closes the burst using the post-beat count.
    always_comb begin
        trigger   = (state_q == S_IDLE) && armed_q && (instruction[15:8] == OPCODE);
        beat      = (state_q == S_REQ) && read_mem_valid && (cnt_q < len_q);
        cnt_post  = beat ? cnt_q + LW'(1) : cnt_q;
        timed_out = (state_q == S_REQ) && !read_mem_valid && !read_mem_finish
                    && (timer_q == TIMER_LAST);
        if (burst_len == '0) begin
            len_clamped = LW'(1);
        end else if (burst_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end else begin
            len_clamped = burst_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (trigger) state_d = S_REQ;
            S_REQ: begin
                if (read_mem_finish) begin
                    state_d = (cnt_post == len_q) ? S_DONE : S_ERR;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        timer_d = timer_q;
        mem_d   = mem_q;
        armed_d = armed_q;
        // Re-arm only once the opcode goes away, so a held opcode fires a single burst.
        if (trigger) begin
            armed_d = 1'b0;
        end else if (instruction[15:8] != OPCODE) begin
            armed_d = 1'b1;
        end
        if (trigger) begin
            req_d   = 1'b1;
            addr_d  = base_addr;
            len_d   = len_clamped;
            cnt_d   = '0;
            timer_d = '0;
        end
        if (state_q == S_REQ) begin
            if (beat) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (cnt_q == LW'(i)) mem_d[i] = in_mem_data;
                end
                cnt_d  = cnt_post;
                addr_d = addr_q + AW'(1);
            end
            if (read_mem_valid || read_mem_finish) begin
                timer_d = '0;
            end else if (!timed_out) begin
                timer_d = timer_q + TW'(1);
            end
            if ((beat && (cnt_post == len_q)) || read_mem_finish || timed_out) begin
                req_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            timer_q <= '0;
            armed_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            timer_q <= timer_d;
            armed_q <= armed_d;
            mem_q   <= mem_d;
        end
    end

    always_comb begin
        is_loaded = (state_q == S_DONE);
        load_err  = (state_q == S_ERR);
        busy      = (state_q == S_REQ);
        load_out  = is_loaded ? mem_q[0] : MDR;
        rd_data   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == LW'(i)) rd_data = mem_q[i];
        end
    end

    assign read_mem_req  = req_q;
    assign read_mem_addr = addr_q;

endmodule

// File: tb/tb_load_burst.sv
// Directed bench for load_burst: stimulus pushes expected completions into exp_q,
// a forked monitor pops and compares whenever is_loaded or load_err is presented.
module tb_load_burst;

    localparam logic [15:0] OP_LOAD = 16'h0200;
    localparam logic [15:0] OP_NOP  = 16'h0100;
    localparam logic [15:0] MDR_VAL = 16'h5A5A;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instruction;
    logic [15:0] base_addr;
    logic [2:0]  burst_len;
    logic [15:0] mdr;
    logic [15:0] in_mem_data;
    logic        read_mem_valid;
    logic        read_mem_finish;
    logic        read_mem_req;
    logic [15:0] read_mem_addr;
    logic [15:0] load_out;
    logic        is_loaded;
    logic        load_err;
    logic        busy;
    logic [2:0]  rd_idx;
    logic [15:0] rd_data;

    // {load_err, load_out} expected when a completion pulse is presented
    logic [16:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    load_burst #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .base_addr(base_addr),
        .burst_len(burst_len), .MDR(mdr), .in_mem_data(in_mem_data),
        .read_mem_valid(read_mem_valid), .read_mem_finish(read_mem_finish),
        .read_mem_req(read_mem_req), .read_mem_addr(read_mem_addr), .load_out(load_out),
        .is_loaded(is_loaded), .load_err(load_err), .busy(busy),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trigger(input logic [15:0] base, input logic [2:0] len);
        instruction = OP_LOAD;
        base_addr   = base;
        burst_len   = len;
        tick();
        instruction = OP_NOP;
    endtask

    task automatic send_beat(input logic [15:0] d);
        read_mem_valid = 1'b1;
        in_mem_data    = d;
        tick();
        read_mem_valid = 1'b0;
    endtask

    task automatic finish_burst(input logic [16:0] e);
        exp_q.push_back(e);
        read_mem_finish = 1'b1;
        tick();
        read_mem_finish = 1'b0;
        tick();
    endtask

    task automatic read_check(input string name, input logic [2:0] idx, input logic [15:0] exp);
        rd_idx = idx;
        #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; instruction = OP_NOP; base_addr = '0; burst_len = '0; mdr = MDR_VAL;
        in_mem_data = '0; read_mem_valid = 1'b0; read_mem_finish = 1'b0; rd_idx = '0;

        fork
            forever begin
                @(negedge clk);
                if (is_loaded || load_err) begin
                    check("pulse_exclusive", 32'(is_loaded && load_err), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'({load_err, load_out}), 32'h1FFFF);
                    end else begin
                        check("completion", 32'({load_err, load_out}), 32'(exp_q.pop_front()));
                    end
                end
            end
        join_none

        // Reset state
        tick(); tick();
        check("rst_req", 32'(read_mem_req), 32'd0);
        check("rst_addr", 32'(read_mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_flags", 32'({is_loaded, load_err}), 32'd0);
        check("rst_load_out", 32'(load_out), 32'(MDR_VAL));
        read_check("rst_buf0", 3'd0, 16'h0000);
        @(negedge clk) rst = 1'b0;
        tick();

        // 1: single word
        trigger(16'h0040, 3'd1);
        check("t1_req", 32'(read_mem_req), 32'd1);
        check("t1_addr", 32'(read_mem_addr), 32'h0040);
        send_beat(16'hBEEF);
        check("t1_req_drop", 32'(read_mem_req), 32'd0);
        finish_burst({1'b0, 16'hBEEF});
        check("t1_load_out_mdr", 32'(load_out), 32'(MDR_VAL));

        // 2: full burst with address wrap, plus an ignored extra beat
        trigger(16'hFFFE, 3'd4);
        check("t2_addr0", 32'(read_mem_addr), 32'hFFFE);
        send_beat(16'h00A1);
        check("t2_addr1", 32'(read_mem_addr), 32'hFFFF);
        send_beat(16'h00A2);
        check("t2_addr2", 32'(read_mem_addr), 32'h0000);
        send_beat(16'h00A3);
        check("t2_addr3", 32'(read_mem_addr), 32'h0001);
        check("t2_req_mid", 32'(read_mem_req), 32'd1);
        send_beat(16'h00A4);
        check("t2_req_drop", 32'(read_mem_req), 32'd0);
        send_beat(16'hDEAD);
        check("t2_addr_hold", 32'(read_mem_addr), 32'h0002);
        finish_burst({1'b0, 16'h00A1});
        read_check("t2_rd0", 3'd0, 16'h00A1);
        read_check("t2_rd1", 3'd1, 16'h00A2);
        read_check("t2_rd2", 3'd2, 16'h00A3);
        read_check("t2_rd3", 3'd3, 16'h00A4);
        read_check("t2_rd_oob", 3'd5, 16'h0000);

        // 3a: last beat and finish together
        trigger(16'h1000, 3'd4);
        send_beat(16'h0B01);
        send_beat(16'h0B02);
        send_beat(16'h0B03);
        read_mem_valid = 1'b1;
        in_mem_data    = 16'h0B04;
        finish_burst({1'b0, 16'h0B01});
        read_mem_valid = 1'b0;
        read_check("t3a_rd3", 3'd3, 16'h0B04);

        // 3b: short burst
        trigger(16'h2000, 3'd4);
        send_beat(16'h0C01);
        send_beat(16'h0C02);
        finish_burst({1'b1, MDR_VAL});
        read_check("t3b_rd1", 3'd1, 16'h0C02);
        read_check("t3b_rd2", 3'd2, 16'h0B03);

        // 4: timeout, load_err 8 cycles after req rises
        trigger(16'h3000, 3'd2);
        exp_q.push_back({1'b1, MDR_VAL});
        for (int k = 1; k < 8; k++) tick();
        check("t4_busy_before", 32'({busy, load_err}), 32'h2);
        tick();
        check("t4_err_at_8", 32'({load_err, read_mem_req}), 32'h2);
        tick();

        // 5: held opcode fires once; len 0 -> 1 word
        instruction = OP_LOAD; base_addr = 16'h4000; burst_len = 3'd0;
        tick();
        send_beat(16'h0D01);
        check("t5_len0_req", 32'(read_mem_req), 32'd0);
        finish_burst({1'b0, 16'h0D01});
        for (int k = 0; k < 14; k++) tick();
        check("t5_no_retrigger", 32'({busy, read_mem_req}), 32'd0);
        instruction = OP_NOP;
        tick();
        // re-armed; len 7 -> 4 words
        trigger(16'h4100, 3'd7);
        check("t5_rearm_busy", 32'(busy), 32'd1);
        send_beat(16'h0E01);
        send_beat(16'h0E02);
        send_beat(16'h0E03);
        check("t5_len7_req_mid", 32'(read_mem_req), 32'd1);
        send_beat(16'h0E04);
        check("t5_len7_req_drop", 32'({read_mem_req, read_mem_addr}), 32'h04104);
        finish_burst({1'b0, 16'h0E01});

        // 6: asynchronous reset mid-burst
        trigger(16'h5000, 3'd4);
        send_beat(16'h0F01);
        send_beat(16'h0F02);
        rst = 1'b1;
        #1;
        check("t6_req_busy", 32'({read_mem_req, busy}), 32'd0);
        read_check("t6_buf0", 3'd0, 16'h0000);
        read_check("t6_buf1", 3'd1, 16'h0000);
        @(negedge clk) rst = 1'b0;
        tick();
        trigger(16'h6000, 3'd1);
        check("t6_after_addr", 32'({read_mem_req, read_mem_addr}), 32'h16000);
        send_beat(16'h1234);
        finish_burst({1'b0, 16'h1234});

        tick(); tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
